// File: rtl/pwm_pkg.sv
//------------------------------------------------------------------------------
// Module      : pwm_pkg
// Description : Shared encodings and helpers for the multi-channel PWM generator.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package pwm_pkg;

    localparam logic MODE_EDGE   = 1'b0;
    localparam logic MODE_CENTER = 1'b1;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // A single channel still needs a one-bit select port.
    function automatic int ch_idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pwm_ch_cmp.sv
//------------------------------------------------------------------------------
// Module      : pwm_ch_cmp
// Description : One PWM channel: shadow/active duty, comparator, output flop.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pwm_ch_cmp #(
    parameter int WIDTH    = 8,
    parameter int DUTY_RST = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_count,
    output logic             o_pwm
);

    localparam logic [WIDTH-1:0] c_duty_rst = WIDTH'(DUTY_RST);

    logic [WIDTH-1:0] r_duty_sh;
    logic [WIDTH-1:0] r_duty_act;
    logic             r_pwm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_duty_sh  <= c_duty_rst;
            r_duty_act <= c_duty_rst;
            r_pwm      <= 1'b0;
        end else begin
            if (i_wr) begin
                r_duty_sh <= i_data;
            end
            // A write landing on the boundary cycle goes straight to active.
            if (i_load) begin
                r_duty_act <= i_wr ? i_data : r_duty_sh;
            end
            r_pwm <= i_en && (i_count < r_duty_act);
        end
    end

    assign o_pwm = r_pwm;

endmodule

`default_nettype wire

// File: rtl/pwm_multi_gen.sv
//------------------------------------------------------------------------------
// Module      : pwm_multi_gen
// Description : Multi-channel PWM generator with shared edge/center counter.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pwm_multi_gen
    import pwm_pkg::*;
#(
    parameter int CH         = 4,
    parameter int WIDTH      = 8,
    parameter int PERIOD_RST = 9,
    parameter int DUTY_RST   = 6
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      period_wr,
    input  logic [WIDTH-1:0]          period_data,
    input  logic                      duty_wr,
    input  logic [ch_idx_w(CH)-1:0]   duty_sel,
    input  logic [WIDTH-1:0]          duty_data,
    input  logic                      mode_wr,
    input  logic                      mode_data,
    output logic [CH-1:0]             pwm_out,
    output logic                      cycle_start
);

    localparam int               SEL_W     = ch_idx_w(CH);
    localparam logic [WIDTH-1:0] c_per_rst = WIDTH'(PERIOD_RST);
    localparam logic [WIDTH-1:0] c_one     = WIDTH'(1);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;
    dir_e             r_dir;
    dir_e             w_dir_nxt;
    logic [WIDTH-1:0] r_per_sh;
    logic [WIDTH-1:0] r_per_act;
    logic             r_mode_sh;
    logic             r_mode_act;
    logic             r_cycle_start;
    logic             w_center;
    logic             w_last;
    logic             w_load;

    // Center mode with a zero period degenerates to edge mode.
    assign w_center = (r_mode_act == MODE_CENTER) && (r_per_act != '0);

    always_comb begin
        w_last = 1'b0;
        if (w_center) begin
            w_last = (r_count == c_one) && ((r_dir == DIR_DOWN) || (r_per_act == c_one));
        end else begin
            w_last = (r_count == r_per_act);
        end
    end

    assign w_load = !en || w_last;

    always_comb begin
        w_count_nxt = r_count + c_one;
        w_dir_nxt   = r_dir;
        if (w_load) begin
            w_count_nxt = '0;
            w_dir_nxt   = DIR_UP;
        end else if (w_center) begin
            if (r_dir == DIR_DOWN) begin
                w_count_nxt = r_count - c_one;
            end else if (r_count == r_per_act) begin
                w_count_nxt = r_count - c_one;
                w_dir_nxt   = DIR_DOWN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_dir   <= DIR_UP;
        end else begin
            r_count <= w_count_nxt;
            r_dir   <= w_dir_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_per_sh      <= c_per_rst;
            r_per_act     <= c_per_rst;
            r_mode_sh     <= MODE_EDGE;
            r_mode_act    <= MODE_EDGE;
            r_cycle_start <= 1'b0;
        end else begin
            if (period_wr) begin
                r_per_sh <= period_data;
            end
            if (mode_wr) begin
                r_mode_sh <= mode_data;
            end
            if (w_load) begin
                r_per_act  <= period_wr ? period_data : r_per_sh;
                r_mode_act <= mode_wr ? mode_data : r_mode_sh;
            end
            r_cycle_start <= en && (r_count == '0);
        end
    end

    assign cycle_start = r_cycle_start;

    generate
        for (genvar i = 0; i < CH; i++) begin : g_ch
            logic w_wr;
            assign w_wr = duty_wr && (duty_sel == SEL_W'(i));

            pwm_ch_cmp #(
                .WIDTH    (WIDTH),
                .DUTY_RST (DUTY_RST)
            ) u_ch (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_en    (en),
                .i_wr    (w_wr),
                .i_data  (duty_data),
                .i_load  (w_load),
                .i_count (r_count),
                .o_pwm   (pwm_out[i])
            );
        end
    endgenerate

endmodule

`default_nettype wire
